// File: rtl/relprime_pkg.sv
// Shared types and constants for the relatively-prime search engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding and the default operand width.
package relprime_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/relprime_gcd.sv
// Subtractive-Euclid GCD datapath: one compare-and-subtract per clock edge.
// Latency: 1 edge to load (go), then one edge per subtraction plus one edge to capture gcd.
// Backpressure: none; the owner pulses go and waits for done before reading gcd.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   go         : load a <= n, b <= m on this edge (takes priority over stepping)
//   n, m       : operands, only sampled when go is high
//   done       : a == b, i.e. the next edge captures the final gcd into g
//   gcd        : captured result register g
module relprime_gcd
  import relprime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] gcd
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;

  // Once a == b the registers stop moving, so the datapath can free-run
  // outside of STEP without disturbing anything; only the larger operand
  // is ever reduced, so no subtraction can underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      g <= '0;
    end else if (go) begin
      a <= n;
      b <= m;
    end else if (a == b) begin
      g <= a;
    end else if (a > b) begin
      a <= a - b;
    end else begin
      b <= b - a;
    end
  end

  assign done = (a == b);
  assign gcd  = g;

endmodule

// File: rtl/relprime_engine.sv
// Finds the smallest m >= 2 coprime to n by trying m = 2, 3, ... with a subtractive GCD.
// Latency: 1 edge for n == 0, else 1 + sum over tried m of (2 + STEP edges), accept edge included.
// Backpressure: start is ignored while busy; result and done hold until the next accepted start.
// Ports:
//   CLK, RESET      : clock and asynchronous active-high reset
//   register_value  : operand n, sampled only on an accepted start
//   start           : level request, accepted in IDLE or DONE
//   out, busy, done : registered result / in-progress / result-valid
//   cycles          : edges spent on the last computation (only with RELPRIME_CYCLE_COUNT_EN)
module relprime_engine
  import relprime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] register_value,
  input  logic             start,
`ifdef RELPRIME_CYCLE_COUNT_EN
  output logic [WIDTH-1:0] cycles,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] m;
  logic             gcd_go;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_val;
  logic             accept;

  assign accept = ((state == IDLE) || (state == DONE)) && start;
  assign gcd_go = (state == LOAD);

  relprime_gcd #(
    .WIDTH(WIDTH)
  ) u_gcd (
    .clk (CLK),
    .rst (RESET),
    .go  (gcd_go),
    .n   (n_r),
    .m   (m),
    .done(gcd_done),
    .gcd (gcd_val)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      n_r   <= '0;
      m     <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (register_value != '0) begin
              n_r   <= register_value;
              m     <= WIDTH'(2);
              busy  <= 1'b1;
              done  <= 1'b0;
              state <= LOAD;
            end else begin
              // gcd(0, m) == m, so nothing >= 2 is coprime; report 0 at once.
              out   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          state <= STEP;
        end
        STEP: begin
          // The datapath captures g on this same edge.
          if (gcd_done) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (gcd_val == WIDTH'(1)) begin
            out   <= m;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            // Cannot wrap: m = n + 1 is always coprime and n fits in WIDTH bits
            // (n = all-ones is odd, so it stops at m = 2).
            m     <= m + WIDTH'(1);
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RELPRIME_CYCLE_COUNT_EN
  // The accepting edge is counted as the first busy edge, so for n != 0 the
  // final value equals the total latency. Freezes in DONE because busy drops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycles <= '0;
    end else if (accept) begin
      cycles <= (register_value != '0) ? WIDTH'(1) : '0;
    end else if (busy && (cycles != '1)) begin
      cycles <= cycles + WIDTH'(1);
    end
  end
`endif

endmodule
